// File: rtl/arp_pkg.sv
// ARP field constants, RX/TX state encodings and the pending-request record
// shared by the responder and its TPA matcher.
package arp_pkg;
  localparam logic [15:0] ETH_TYPE_ARP = 16'h0806;
  localparam logic [15:0] HTYPE_ETH    = 16'h0001;
  localparam logic [15:0] PTYPE_IPV4   = 16'h0800;
  localparam logic [7:0]  HLEN         = 8'd6;
  localparam logic [7:0]  PLEN         = 8'd4;
  localparam logic [15:0] OP_REQ       = 16'h0001;
  localparam logic [15:0] OP_REPLY     = 16'h0002;
  localparam int          ARP_LEN      = 42;
  localparam int          ETH_MIN_LEN  = 60;
  localparam int          IDX_W        = 3;  // wide enough for NUM_IP up to 8

  // Request header bytes 12..21 as they appear on the wire.
  localparam logic [79:0] REQ_HDR = {ETH_TYPE_ARP, HTYPE_ETH, PTYPE_IPV4, HLEN, PLEN, OP_REQ};

  typedef enum logic [1:0] {RX_PARSE, RX_DRAIN, RX_ERR} rx_state_t;
  typedef enum logic       {TX_IDLE, TX_SEND} tx_state_t;

  typedef struct packed {
    logic [47:0]      sha;
    logic [31:0]      spa;
    logic [IDX_W-1:0] idx;
    logic             grat;
  } pend_t;

  function automatic logic [7:0] req_hdr_byte(input logic [5:0] pos);
    logic [3:0] k;
    k = 4'(pos - 6'd12);
    return REQ_HDR[(9 - k)*8 +: 8];
  endfunction
endpackage

// File: rtl/arp_ip_match.sv
// Combinational TPA compare against NUM_IP enabled entries; lowest index wins.
// Zero latency, no flow control.
module arp_ip_match
  import arp_pkg::*;
#(
  parameter int NUM_IP = 4
) (
  input  logic [31:0]          tpa_i,
  input  logic [32*NUM_IP-1:0] ip_i,
  input  logic [NUM_IP-1:0]    en_i,
  output logic                 hit_o,
  output logic [IDX_W-1:0]     idx_o
);
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = NUM_IP - 1; i >= 0; i--) begin
      if (en_i[i] && (ip_i[32*i +: 32] == tpa_i)) begin
        hit_o = 1'b1;
        idx_o = IDX_W'(i);
      end
    end
  end
endmodule

// File: rtl/arp_responder_multi.sv
// Multi-IP ARP responder: reply starts 2 cycles after the committing RX_LAST, one pending slot,
// TX held on !TX_READY, RX never stalled. ARP_RESPONDER_GRATUITOUS_EN adds ANNOUNCE/ANNOUNCE_IDX.
module arp_responder_multi
  import arp_pkg::*;
#(
  parameter  int NUM_IP     = 4,
  parameter  int PAD_TO_MIN = 1,
  parameter  int CNT_W      = 16,
  localparam int AIDX_W     = (NUM_IP > 1) ? $clog2(NUM_IP) : 1
) (
  input  logic                 CLK,
  input  logic                 ARESET_N,
  input  logic [47:0]          MY_MAC,
  input  logic [32*NUM_IP-1:0] MY_IPV4,
  input  logic [NUM_IP-1:0]    IP_EN,
  input  logic                 RX_VALID,
  input  logic [7:0]           RX_DATA,
  input  logic                 RX_LAST,
  output logic                 TX_VALID,
  output logic [7:0]           TX_DATA,
  output logic                 TX_LAST,
  input  logic                 TX_READY,
  output logic                 BUSY,
  output logic [CNT_W-1:0]     REQ_COUNT,
  output logic [CNT_W-1:0]     DROP_COUNT
`ifdef ARP_RESPONDER_GRATUITOUS_EN
  ,
  input  logic                 ANNOUNCE,
  input  logic [AIDX_W-1:0]    ANNOUNCE_IDX
`endif
);
  localparam int TX_LEN = (PAD_TO_MIN != 0) ? ETH_MIN_LEN : ARP_LEN;

  rx_state_t        rx_q;
  logic [5:0]       rx_cnt_q;
  logic             bc_q, me_q;
  logic [47:0]      sha_q;
  logic [31:0]      spa_q;
  logic [23:0]      tpa_q;
  logic [IDX_W-1:0] idx_q;

  tx_state_t        tx_q;
  logic [5:0]       tx_cnt_q;
  pend_t            cur_q, slot_q;
  logic             slot_vld_q;
  logic             tx_vld_q, tx_last_q;
  logic [7:0]       tx_dat_q;
  logic [CNT_W-1:0] req_cnt_q, drop_cnt_q;

  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic [7:0]       mac_b;
  logic             bc_n, me_n, fail, commit, accept, drop, take;
  logic [IDX_W-1:0] commit_idx;

  arp_ip_match #(.NUM_IP(NUM_IP)) u_match (
    .tpa_i ({tpa_q, RX_DATA}),
    .ip_i  (MY_IPV4),
    .en_i  (IP_EN),
    .hit_o (hit),
    .idx_o (hit_idx)
  );

  // Destination MAC is accepted if every byte so far is broadcast or every byte is ours.
  always_comb begin
    mac_b = MY_MAC[47:40];
    for (int k = 1; k < 6; k++)
      if (rx_cnt_q == 6'(k)) mac_b = MY_MAC[8*(5-k) +: 8];
    bc_n = (RX_DATA == 8'hff) && ((rx_cnt_q == 6'd0) || bc_q);
    me_n = (RX_DATA == mac_b) && ((rx_cnt_q == 6'd0) || me_q);
    fail = 1'b0;
    if (rx_cnt_q < 6'd6)                              fail = !(bc_n || me_n);
    else if ((rx_cnt_q >= 6'd12) && (rx_cnt_q <= 6'd21)) fail = (RX_DATA != req_hdr_byte(rx_cnt_q));
    else if (rx_cnt_q == 6'd41)                       fail = !hit;
    commit     = 1'b0;
    commit_idx = idx_q;
    if (RX_VALID && RX_LAST) begin
      if (rx_q == RX_DRAIN) commit = 1'b1;
      else if ((rx_q == RX_PARSE) && (rx_cnt_q == 6'd41) && !fail) begin
        commit     = 1'b1;
        commit_idx = hit_idx;
      end
    end
  end

  always_ff @(posedge CLK or negedge ARESET_N) begin
    if (!ARESET_N) begin
      rx_q     <= RX_PARSE;
      rx_cnt_q <= '0;
      bc_q     <= 1'b0;
      me_q     <= 1'b0;
      sha_q    <= '0;
      spa_q    <= '0;
      tpa_q    <= '0;
      idx_q    <= '0;
    end else if (RX_VALID) begin
      case (rx_q)
        RX_PARSE: begin
          bc_q <= bc_n;
          me_q <= me_n;
          if ((rx_cnt_q >= 6'd22) && (rx_cnt_q <= 6'd27)) sha_q <= {sha_q[39:0], RX_DATA};
          if ((rx_cnt_q >= 6'd28) && (rx_cnt_q <= 6'd31)) spa_q <= {spa_q[23:0], RX_DATA};
          if ((rx_cnt_q >= 6'd38) && (rx_cnt_q <= 6'd40)) tpa_q <= {tpa_q[15:0], RX_DATA};
          if (fail) begin
            rx_q     <= RX_LAST ? RX_PARSE : RX_ERR;
            rx_cnt_q <= '0;
          end else if (RX_LAST) begin
            rx_cnt_q <= '0;
          end else if (rx_cnt_q == 6'd41) begin
            rx_q     <= RX_DRAIN;
            idx_q    <= hit_idx;
            rx_cnt_q <= '0;
          end else begin
            rx_cnt_q <= rx_cnt_q + 6'd1;
          end
        end
        RX_DRAIN, RX_ERR: if (RX_LAST) rx_q <= RX_PARSE;
        default: rx_q <= RX_PARSE;
      endcase
    end
  end

  // The slot can be taken at reply start or on the last handshake of the previous reply.
  assign take   = slot_vld_q && ((tx_q == TX_IDLE) || ((tx_q == TX_SEND) && TX_READY && tx_last_q));
  assign accept = commit && (!slot_vld_q || take);
  assign drop   = commit && slot_vld_q && !take;

`ifdef ARP_RESPONDER_GRATUITOUS_EN
  logic             ann_ok;
  logic [IDX_W-1:0] ann_idx;
  logic [31:0]      ann_ip;
  assign ann_idx = IDX_W'(ANNOUNCE_IDX);
  assign ann_ok  = ANNOUNCE && (tx_q == TX_IDLE) && !slot_vld_q && !commit;
  always_comb begin
    ann_ip = MY_IPV4[31:0];
    for (int i = 1; i < NUM_IP; i++)
      if (ann_idx == IDX_W'(i)) ann_ip = MY_IPV4[32*i +: 32];
  end
`endif

  pend_t                src;
  logic [5:0]           nxt;
  logic [31:0]          src_ip;
  logic [ARP_LEN*8-1:0] frame;
  logic [7:0]           nxt_byte;

  always_comb begin
    src    = take ? slot_q : cur_q;
    nxt    = take ? 6'd0 : (tx_cnt_q + 6'd1);
    src_ip = MY_IPV4[31:0];
    for (int i = 1; i < NUM_IP; i++)
      if (src.idx == IDX_W'(i)) src_ip = MY_IPV4[32*i +: 32];
    frame = {src.grat ? 48'hffff_ffff_ffff : src.sha, MY_MAC, ETH_TYPE_ARP, HTYPE_ETH, PTYPE_IPV4,
             HLEN, PLEN, src.grat ? OP_REQ : OP_REPLY, MY_MAC, src_ip, src.sha, src.spa};
    nxt_byte = 8'h00;
    for (int k = 0; k < ARP_LEN; k++)
      if (nxt == 6'(k)) nxt_byte = frame[8*(ARP_LEN-1-k) +: 8];
  end

  always_ff @(posedge CLK or negedge ARESET_N) begin
    if (!ARESET_N) begin
      tx_q       <= TX_IDLE;
      tx_cnt_q   <= '0;
      cur_q      <= '0;
      slot_q     <= '0;
      slot_vld_q <= 1'b0;
      tx_vld_q   <= 1'b0;
      tx_last_q  <= 1'b0;
      tx_dat_q   <= '0;
      req_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (take) begin
        tx_q      <= TX_SEND;
        cur_q     <= slot_q;
        tx_cnt_q  <= '0;
        tx_vld_q  <= 1'b1;
        tx_dat_q  <= nxt_byte;
        tx_last_q <= 1'b0;
      end else if ((tx_q == TX_SEND) && TX_READY) begin
        if (tx_last_q) begin
          tx_q      <= TX_IDLE;
          tx_vld_q  <= 1'b0;
          tx_last_q <= 1'b0;
          tx_dat_q  <= '0;
        end else begin
          tx_cnt_q  <= nxt;
          tx_dat_q  <= nxt_byte;
          tx_last_q <= (nxt == 6'(TX_LEN - 1));
        end
      end

      if (accept) begin
        slot_q     <= '{sha: sha_q, spa: spa_q, idx: commit_idx, grat: 1'b0};
        slot_vld_q <= 1'b1;
`ifdef ARP_RESPONDER_GRATUITOUS_EN
      end else if (ann_ok) begin
        slot_q     <= '{sha: 48'h0, spa: ann_ip, idx: ann_idx, grat: 1'b1};
        slot_vld_q <= 1'b1;
`endif
      end else if (take) begin
        slot_vld_q <= 1'b0;
      end

      if (accept && (req_cnt_q != '1))  req_cnt_q  <= req_cnt_q + CNT_W'(1);
      if (drop && (drop_cnt_q != '1))   drop_cnt_q <= drop_cnt_q + CNT_W'(1);
    end
  end

  assign TX_VALID   = tx_vld_q;
  assign TX_DATA    = tx_dat_q;
  assign TX_LAST    = tx_last_q;
  assign BUSY       = (tx_q != TX_IDLE) || slot_vld_q;
  assign REQ_COUNT  = req_cnt_q;
  assign DROP_COUNT = drop_cnt_q;
endmodule

// File: tb/tb_arp_responder_multi.sv
// Bench for arp_responder_multi: directed vector table, hand-written corner sequences and a
// randomized phase checked against a frame-level reference model.
module tb_arp_responder_multi;
  logic         CLK;
  logic         ARESET_N;
  logic [47:0]  MY_MAC;
  logic [127:0] MY_IPV4;
  logic [3:0]   IP_EN;
  logic         RX_VALID;
  logic [7:0]   RX_DATA;
  logic         RX_LAST;
  logic         TX_VALID;
  logic [7:0]   TX_DATA;
  logic         TX_LAST;
  logic         TX_READY;
  logic         BUSY;
  logic [15:0]  REQ_COUNT;
  logic [15:0]  DROP_COUNT;
`ifdef ARP_RESPONDER_GRATUITOUS_EN
  logic         ANNOUNCE;
  logic [1:0]   ANNOUNCE_IDX;
`endif

  arp_responder_multi #(.NUM_IP(4), .PAD_TO_MIN(1), .CNT_W(16)) dut (
    .CLK(CLK), .ARESET_N(ARESET_N), .MY_MAC(MY_MAC), .MY_IPV4(MY_IPV4), .IP_EN(IP_EN),
    .RX_VALID(RX_VALID), .RX_DATA(RX_DATA), .RX_LAST(RX_LAST),
    .TX_VALID(TX_VALID), .TX_DATA(TX_DATA), .TX_LAST(TX_LAST), .TX_READY(TX_READY),
    .BUSY(BUSY), .REQ_COUNT(REQ_COUNT), .DROP_COUNT(DROP_COUNT)
`ifdef ARP_RESPONDER_GRATUITOUS_EN
    , .ANNOUNCE(ANNOUNCE), .ANNOUNCE_IDX(ANNOUNCE_IDX)
`endif
  );

  localparam logic [47:0] LOCAL_MAC = 48'h02_11_22_33_44_55;
  localparam logic [47:0] BCAST     = 48'hff_ff_ff_ff_ff_ff;
  localparam logic [47:0] OTHER_MAC = 48'h02_00_00_00_00_01;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int exp_req = 0;
  int exp_drop = 0;
  bit rnd_ready = 0;
  bit ready_fix = 1;

  logic [7:0] fq[$];
  logic [7:0] expq[$];
  bit         explast[$];
  logic [7:0] rxq[$];
  bit         lastq[$];
  int         cycq[$];
  logic [31:0] ipv[4];

  bit         p_stall = 0;
  logic [7:0] p_dat;
  logic       p_last;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    #1;
    TX_READY = rnd_ready ? 1'($urandom_range(1)) : ready_fix;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Output monitor and hold-under-stall check, sampled mid-cycle.
  always @(negedge CLK) begin
    if (!ARESET_N) begin
      p_stall = 0;
    end else begin
      if (p_stall)
        chk("stall hold", {TX_VALID, TX_LAST, TX_DATA}, {1'b1, p_last, p_dat});
      if (TX_VALID && TX_READY) begin
        rxq.push_back(TX_DATA);
        lastq.push_back(TX_LAST);
        cycq.push_back(cyc);
      end
      p_stall = TX_VALID && !TX_READY;
      p_dat   = TX_DATA;
      p_last  = TX_LAST;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_f(input logic [47:0] v, input int n);
    for (int b = n - 1; b >= 0; b--) fq.push_back(v[8*b +: 8]);
  endtask

  task automatic push_e(input logic [47:0] v, input int n);
    for (int b = n - 1; b >= 0; b--) begin
      expq.push_back(v[8*b +: 8]);
      explast.push_back(1'b0);
    end
  endtask

  task automatic set_ips();
    MY_IPV4 = {ipv[3], ipv[2], ipv[1], ipv[0]};
  endtask

  task automatic std_ips();
    ipv[0] = 32'h0a000001; ipv[1] = 32'h0a000002; ipv[2] = 32'h0a000003; ipv[3] = 32'h0a000004;
    set_ips();
  endtask

  // Expected frame, field by field in wire order, appended to the expected stream.
  task automatic build_exp(input logic [47:0] sha, input logic [31:0] spa, input logic [31:0] ip,
                           input bit grat);
    push_e(grat ? BCAST : sha, 6);
    push_e(LOCAL_MAC, 6);
    push_e(48'h0806, 2); push_e(48'h0001, 2); push_e(48'h0800, 2);
    push_e(48'h06, 1);   push_e(48'h04, 1);
    push_e(grat ? 48'h0001 : 48'h0002, 2);
    push_e(LOCAL_MAC, 6);
    push_e({16'h0, ip}, 4);
    push_e(grat ? 48'h0 : sha, 6);
    push_e({16'h0, grat ? ip : spa}, 4);
    push_e(48'h0, 18);
    explast[explast.size() - 1] = 1'b1;
  endtask

  task automatic send_frame(input logic [47:0] dst, input logic [15:0] et, input logic [15:0] op,
                            input logic [47:0] sha, input logic [31:0] spa, input logic [31:0] tpa,
                            input int len, input bit gaps);
    fq.delete();
    push_f(dst, 6); push_f(sha, 6); push_f({32'h0, et}, 2);
    push_f(48'h0001, 2); push_f(48'h0800, 2); push_f(48'h06, 1); push_f(48'h04, 1);
    push_f({32'h0, op}, 2); push_f(sha, 6); push_f({16'h0, spa}, 4); push_f(48'h0, 6);
    push_f({16'h0, tpa}, 4); push_f(48'h0, 18); push_f({16'h0, $urandom()}, 4);
    for (int i = 0; i < len; i++) begin
      if (gaps) begin
        while ($urandom_range(3) == 0) begin
          RX_VALID = 1'b0; RX_LAST = 1'b0; tick();
        end
      end
      RX_VALID = 1'b1; RX_DATA = fq[i]; RX_LAST = (i == len - 1); tick();
    end
    RX_VALID = 1'b0; RX_LAST = 1'b0;
  endtask

  task automatic clear_q();
    rxq.delete(); lastq.delete(); expq.delete(); explast.delete(); cycq.delete();
  endtask

  task automatic check_reply(input string nm);
    int n, t, bad_d, bad_l;
    n = expq.size();
    t = 0;
    while ((rxq.size() < n) && (t < 3000)) begin tick(); t++; end
    repeat (20) tick();
    chk({nm, " length"}, rxq.size(), n);
    bad_d = 0; bad_l = 0;
    for (int i = 0; (i < n) && (i < rxq.size()); i++) begin
      if (rxq[i] !== expq[i]) bad_d++;
      if (lastq[i] !== explast[i]) bad_l++;
    end
    chk({nm, " bytes differing"}, bad_d, 0);
    chk({nm, " TX_LAST misplaced"}, bad_l, 0);
    rxq.delete(); lastq.delete(); expq.delete(); explast.delete();
  endtask

  task automatic expect_none(input string nm);
    repeat (100) tick();
    chk({nm, " unexpected bytes"}, rxq.size(), 0);
    clear_q();
  endtask

  typedef struct {
    logic [47:0] dst;
    logic [15:0] et;
    logic [15:0] op;
    logic [31:0] tpa;
    logic [3:0]  en;
    bit          rep;
  } vec_t;
  vec_t vt[8];

  initial begin
    logic [47:0] sha;
    logic [31:0] spa, tpa;
    int          corrupt, len;
    bit          hit;
    logic [47:0] dst;
    logic [15:0] et;

    ARESET_N = 1'b0; MY_MAC = LOCAL_MAC; IP_EN = 4'b1111;
    RX_VALID = 1'b0; RX_DATA = 8'h00; RX_LAST = 1'b0;
`ifdef ARP_RESPONDER_GRATUITOUS_EN
    ANNOUNCE = 1'b0; ANNOUNCE_IDX = 2'd0;
`endif
    std_ips();

    vt[0] = '{BCAST,     16'h0806, 16'h0001, 32'h0a000003, 4'b1100, 1'b1};
    vt[1] = '{BCAST,     16'h0800, 16'h0001, 32'h0a000003, 4'b1111, 1'b0};
    vt[2] = '{BCAST,     16'h0806, 16'h0001, 32'h0a000009, 4'b1111, 1'b0};
    vt[3] = '{OTHER_MAC, 16'h0806, 16'h0001, 32'h0a000003, 4'b1111, 1'b0};
    vt[4] = '{LOCAL_MAC, 16'h0806, 16'h0001, 32'h0a000001, 4'b1111, 1'b1};
    vt[5] = '{BCAST,     16'h0806, 16'h0002, 32'h0a000002, 4'b1111, 1'b0};
    vt[6] = '{BCAST,     16'h0806, 16'h0001, 32'h0a000001, 4'b1110, 1'b0};
    vt[7] = '{BCAST,     16'h0806, 16'h0001, 32'h0a000004, 4'b1000, 1'b1};

    repeat (3) tick();
    @(negedge CLK);
    chk("reset TX_VALID", TX_VALID, 0);
    chk("reset TX_DATA", TX_DATA, 0);
    chk("reset TX_LAST", TX_LAST, 0);
    chk("reset BUSY", BUSY, 0);
    chk("reset REQ_COUNT", REQ_COUNT, 0);
    chk("reset DROP_COUNT", DROP_COUNT, 0);
    tick();
    ARESET_N = 1'b1;
    repeat (2) tick();

    for (int v = 0; v < 8; v++) begin
      IP_EN = vt[v].en;
      sha = 48'h0a_bb_cc_dd_ee_00 + 48'(v);
      spa = 32'hc0a80100 + 32'(v);
      send_frame(vt[v].dst, vt[v].et, vt[v].op, sha, spa, vt[v].tpa, 64, 1'b1);
      if (vt[v].rep) begin
        build_exp(sha, spa, vt[v].tpa, 1'b0);
        exp_req++;
        check_reply($sformatf("vec%0d reply", v));
      end else begin
        expect_none($sformatf("vec%0d", v));
      end
      chk($sformatf("vec%0d REQ_COUNT", v), REQ_COUNT, exp_req);
      chk($sformatf("vec%0d DROP_COUNT", v), DROP_COUNT, exp_drop);
    end

    // RX_LAST on byte 41 commits directly; first TX_VALID two cycles later.
    IP_EN = 4'b1111;
    send_frame(BCAST, 16'h0806, 16'h0001, 48'h00_11_aa_bb_cc_dd, 32'hc0a80007, 32'h0a000002, 42, 1'b0);
    @(negedge CLK);
    chk("latency cycle1 TX_VALID", TX_VALID, 0);
    chk("latency cycle1 BUSY", BUSY, 1);
    @(negedge CLK);
    chk("latency cycle2 TX_VALID", TX_VALID, 1);
    build_exp(48'h00_11_aa_bb_cc_dd, 32'hc0a80007, 32'h0a000002, 1'b0);
    exp_req++;
    check_reply("direct commit reply");
    chk("direct commit BUSY", BUSY, 0);

    // Three requests while stalled: one in flight, one pending, one dropped.
    ready_fix = 1'b0;
    repeat (2) tick();
    for (int r = 0; r < 3; r++)
      send_frame(BCAST, 16'h0806, 16'h0001, 48'h00_22_00_00_00_00 + 48'(r), 32'hc0a80a00 + 32'(r),
                 32'h0a000004, 60, 1'b0);
    repeat (3) tick();
    exp_req += 2; exp_drop += 1;
    chk("stalled REQ_COUNT", REQ_COUNT, exp_req);
    chk("stalled DROP_COUNT", DROP_COUNT, exp_drop);
    chk("stalled BUSY", BUSY, 1);
    clear_q();
    build_exp(48'h00_22_00_00_00_00, 32'hc0a80a00, 32'h0a000004, 1'b0);
    build_exp(48'h00_22_00_00_00_01, 32'hc0a80a01, 32'h0a000004, 1'b0);
    ready_fix = 1'b1;
    check_reply("back-to-back replies");
    chk("back-to-back handshakes", cycq.size(), 120);
    if (cycq.size() == 120) chk("back-to-back gap cycles", cycq[119] - cycq[0], 119);
    cycq.delete();

    // Truncated request.
    send_frame(BCAST, 16'h0806, 16'h0001, 48'h00_33_00_00_00_01, 32'hc0a80b01, 32'h0a000001, 31, 1'b0);
    expect_none("short frame");
    chk("short frame REQ_COUNT", REQ_COUNT, exp_req);

    // Reset in the middle of a reply.
    send_frame(BCAST, 16'h0806, 16'h0001, 48'h00_44_00_00_00_01, 32'hc0a80c01, 32'h0a000003, 60, 1'b0);
    begin
      int t = 0;
      while ((rxq.size() < 20) && (t < 500)) begin @(negedge CLK); t++; end
    end
    chk("pre-reset bytes seen", (rxq.size() >= 20), 1);
    @(posedge CLK); #1;
    ARESET_N = 1'b0;
    @(negedge CLK);
    chk("mid-reply reset TX_VALID", TX_VALID, 0);
    chk("mid-reply reset BUSY", BUSY, 0);
    chk("mid-reply reset REQ_COUNT", REQ_COUNT, 0);
    chk("mid-reply reset DROP_COUNT", DROP_COUNT, 0);
    exp_req = 0; exp_drop = 0;
    repeat (2) tick();
    ARESET_N = 1'b1;
    clear_q();
    tick();
    send_frame(LOCAL_MAC, 16'h0806, 16'h0001, 48'h00_55_00_00_00_01, 32'hc0a80d01, 32'h0a000002, 60, 1'b1);
    build_exp(48'h00_55_00_00_00_01, 32'hc0a80d01, 32'h0a000002, 1'b0);
    exp_req++;
    check_reply("post-reset reply");
    chk("post-reset REQ_COUNT", REQ_COUNT, exp_req);

`ifdef ARP_RESPONDER_GRATUITOUS_EN
    ANNOUNCE = 1'b1; ANNOUNCE_IDX = 2'd1; tick();
    ANNOUNCE = 1'b0;
    build_exp(48'h0, 32'h0, ipv[1], 1'b1);
    check_reply("gratuitous frame");
    chk("gratuitous REQ_COUNT", REQ_COUNT, exp_req);
    chk("gratuitous DROP_COUNT", DROP_COUNT, exp_drop);
    ready_fix = 1'b0;
    send_frame(BCAST, 16'h0806, 16'h0001, 48'h00_66_00_00_00_01, 32'hc0a80e01, 32'h0a000001, 60, 1'b0);
    repeat (3) tick();
    chk("announce-while-busy BUSY", BUSY, 1);
    ANNOUNCE = 1'b1; ANNOUNCE_IDX = 2'd2; tick();
    ANNOUNCE = 1'b0;
    exp_req++;
    build_exp(48'h00_66_00_00_00_01, 32'hc0a80e01, 32'h0a000001, 1'b0);
    ready_fix = 1'b1;
    check_reply("announce-while-busy ignored");
    chk("announce-while-busy REQ_COUNT", REQ_COUNT, exp_req);
`endif

    // Randomized requests under 50% TX stalls, checked against a frame-level model.
    rnd_ready = 1'b1;
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < 4; i++) ipv[i] = 32'h0a000001 + 32'($urandom_range(5));
      set_ips();
      IP_EN   = 4'($urandom());
      tpa     = 32'h0a000001 + 32'($urandom_range(5));
      sha     = {16'h0a00, $urandom()};
      spa     = $urandom();
      corrupt = $urandom_range(5);
      dst     = $urandom_range(1) ? LOCAL_MAC : BCAST;
      et      = 16'h0806;
      len     = 60 + $urandom_range(4);
      if (corrupt == 3) et = 16'h86dd;
      if (corrupt == 4) dst = OTHER_MAC;
      if (corrupt == 5) len = 10 + $urandom_range(30);
      hit = 1'b0;
      for (int i = 0; i < 4; i++) if (IP_EN[i] && (ipv[i] == tpa)) hit = 1'b1;
      send_frame(dst, et, 16'h0001, sha, spa, tpa, len, 1'b1);
      if ((corrupt < 3) && hit) begin
        build_exp(sha, spa, tpa, 1'b0);
        exp_req++;
        check_reply($sformatf("random%0d reply", it));
      end else begin
        expect_none($sformatf("random%0d", it));
      end
      chk($sformatf("random%0d REQ_COUNT", it), REQ_COUNT, exp_req);
    end
    rnd_ready = 1'b0;
    repeat (5) tick();
    chk("final DROP_COUNT", DROP_COUNT, exp_drop);
    chk("final BUSY", BUSY, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
